serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised, bit-serial two's-complement adder/subtractor: the multi-cycle successor to the combinational half adder. It resolves one bit per clock through a single full-adder slice built from two half adders. It is the arithmetic primitive for the sequential shift-and-add multiplier path, where area matters more than latency. It uses a start/busy/done handshake and reports unsigned carry and signed overflow.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; sole clock of the block.
- rst_n  input  1  reset, synchronous, active-low; sampled on rising clk.
- start  input  1  request; accepted only when state is IDLE.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- sum  output  WIDTH  result of last completed operation.
- cout  output  1  carry out of MSB. For subtract this is 1 = no borrow, i.e. unsigned A ≥ B.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse on completion.

## Operation
- Two states:
  - IDLE: busy=0.
  - RUN: busy=1; processes one bit per cycle.
- IDLE → RUN when start=1 is sampled:
  - latch a_sh=A and b_sh=(sub ? ~B : B);
  - set carry=sub, bit counter=0, clear internal result shift register.
- Each RUN cycle processes bit 0 first, then upward:
  - x = a_sh[0]^b_sh[0]; s = x^carry;
  - carry_next = (a_sh[0]&b_sh[0]) | (x&carry).
  - a_sh and b_sh shift right by one; s enters result register at MSB, shifting right.
  - On processing bit WIDTH−1, record the carry into the MSB (the carry before update) for ovf.
- RUN → IDLE after WIDTH bit cycles. At that edge:
  - load sum, cout and ovf from the internal state;
  - assert done for the next cycle.
- sum, cout and ovf change only at completion. They hold their value otherwise, including while the next operation runs.
- start while busy=1 is ignored: no queueing, no effect on the operation in flight. A, B and sub may change freely during RUN.
- start is accepted in the cycle where done=1, since the state is already IDLE. This allows back-to-back operations.
- Reset (rst_n=0 at any edge, including mid-RUN):
  - state → IDLE; sum=0, cout=0, ovf=0, busy=0, done=0;
  - the aborted operation produces no done and no result update.
- Width rules:
  - sum is truncated modulo 2^WIDTH;
  - cout is the (WIDTH+1)th bit of the unsigned sum of A and the effective B with carry-in;
  - ovf is computed for signed interpretation.

## Timing
- Edge 0: start sampled high in IDLE.
- Cycles 1..WIDTH: busy=1, one bit per cycle.
- Edge WIDTH: results registered.
- Cycle WIDTH+1: done=1, busy=0, sum/cout/ovf valid. Latency from start edge to done is WIDTH+1 cycles.
- Throughput: one operation per WIDTH+1 cycles, with start held or re-asserted in the done cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- done never coincides with busy=1. busy deasserts in the same cycle done asserts.
- Simultaneous rst_n=0 and start=1: reset wins and start is discarded.

## Test plan
- WIDTH=8, add, A=200, B=100 → sum=44 (0x2C), cout=1, ovf=0. busy high exactly 8 cycles; done one cycle at edge 9.
- WIDTH=8, add, A=100, B=100 → sum=0xC8, cout=0, ovf=1. Then sub, A=0x80, B=0x01 → sum=0x7F, cout=1, ovf=1.
- WIDTH=8, sub, A=5, B=7 → sum=0xFE, cout=0, ovf=0. Change A/B/sub and pulse start mid-RUN → result unchanged, no extra done.
- Back-to-back: hold start high with A=1, B=1, then A=2, B=3 presented in the done cycle → done pulses 9 cycles apart; sum=2, then sum=5.
- Reset at RUN cycle 4 of an operation → next cycle busy=0, done=0, sum/cout/ovf=0; no done afterwards. A new start then completes normally.
- WIDTH=2, exhaustive: all 16 A/B pairs × both modes → sum, cout and ovf match a reference model. WIDTH=32: random 1000 ops checked against the model.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice (two half
// adders) resolves one bit per clock, LSB first, with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, ovf_reg, done_reg;

  logic ha1_s, ha1_c, ha2_c, bit_s, carry_next, last_bit;

  // Full-adder slice as two cascaded half adders.
  assign ha1_s      = a_sh_reg[0] ^ b_sh_reg[0];
  assign ha1_c      = a_sh_reg[0] & b_sh_reg[0];
  assign bit_s      = ha1_s ^ carry_reg;
  assign ha2_c      = ha1_s & carry_reg;
  assign carry_next = ha1_c | ha2_c;
  assign last_bit   = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = done_reg;
    sum  = sum_reg;
    cout = cout_reg;
    ovf  = ovf_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE && start) begin
        a_sh_reg   <= A;
        b_sh_reg   <= sub ? ~B : B;
        carry_reg  <= sub;
        cnt_reg    <= '0;
        res_sh_reg <= '0;
      end else if (state_reg == RUN) begin
        a_sh_reg   <= a_sh_reg >> 1;
        b_sh_reg   <= b_sh_reg >> 1;
        res_sh_reg <= {bit_s, res_sh_reg[WIDTH-1:1]};
        carry_reg  <= carry_next;
        cnt_reg    <= cnt_reg + CW'(1);
        // carry_reg is the carry into the MSB while the last bit is processed.
        if (last_bit) begin
          sum_reg  <= {bit_s, res_sh_reg[WIDTH-1:1]};
          cout_reg <= carry_next;
          ovf_reg  <= carry_reg ^ carry_next;
          done_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and model-checked bench for serial_adder at WIDTH 8, 2 and 32.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 0, sub8 = 0, cout8, ovf8, busy8, done8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       start2 = 0, sub2 = 0, cout2, ovf2, busy2, done2;
  logic [1:0] a2 = 0, b2 = 0, sum2;
  logic        start32 = 0, sub32 = 0, cout32, ovf32, busy32, done32;
  logic [31:0] a32 = 0, b32 = 0, sum32;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .A(a8), .B(b8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8));
  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .A(a2), .B(b2),
    .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2));
  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .A(a32), .B(b32),
    .sum(sum32), .cout(cout32), .ovf(ovf32), .busy(busy32), .done(done32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic s);
    case (w)
      2:       begin start2 = st;  a2 = a[1:0];  b2 = b[1:0];  sub2 = s;  end
      32:      begin start32 = st; a32 = a;      b32 = b;      sub32 = s; end
      default: begin start8 = st;  a8 = a[7:0];  b8 = b[7:0];  sub8 = s;  end
    endcase
  endtask

  function automatic logic busy_of(input int w);
    return (w == 2) ? busy2 : (w == 32) ? busy32 : busy8;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 2) ? done2 : (w == 32) ? done32 : done8;
  endfunction

  // {ovf, cout, sum zero-extended to 32 bits}
  function automatic logic [33:0] res_of(input int w);
    case (w)
      2:       return {ovf2, cout2, 30'd0, sum2};
      32:      return {ovf32, cout32, sum32};
      default: return {ovf8, cout8, 24'd0, sum8};
    endcase
  endfunction

  // Reference: wide unsigned sum for cout, sign rule for ovf.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic s);
    logic [63:0] mask, am, bm, full, sm;
    logic        c, o;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, a} & mask;
    bm   = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
    full = am + bm + {63'd0, s};
    sm   = full & mask;
    c    = full[w];
    o    = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
    return {o, c, sm[31:0]};
  endfunction

  // Launch one op and wait until busy drops; n = cycles busy was seen high.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, output int n);
    drive(w, 1'b1, a, b, s);
    @(posedge clk); #1;
    drive(w, 1'b0, a, b, s);
    n = 0;
    while (busy_of(w) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic op8_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [7:0] es, input logic ec,
                           input logic eo);
    int n;
    run_op(8, {24'd0, a}, {24'd0, b}, s, n);
    chk({tag, "_busycycles"}, 64'(n), 64'd8);
    chk({tag, "_done"}, {63'd0, done8}, 64'd1);
    chk({tag, "_sum"}, {56'd0, sum8}, {56'd0, es});
    chk({tag, "_cout_ovf"}, {62'd0, cout8, ovf8}, {62'd0, ec, eo});
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, {63'd0, done8}, 64'd0);
  endtask

  initial begin
    int n, t, dcount;
    logic [31:0] ra, rb;
    logic        rs;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {45'd0, sum8, cout8, ovf8, busy8, done8}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8_check("add_200_100", 8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0);
    op8_check("add_100_100", 8'd100, 8'd100, 1'b0, 8'hC8, 1'b0, 1'b1);
    op8_check("sub_80_01",   8'h80,  8'h01,  1'b1, 8'h7F, 1'b1, 1'b1);

    // Inputs and start toggled mid-run must not disturb the operation.
    drive(8, 1'b1, 32'd5, 32'd7, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'd5, 32'd7, 1'b1);
    n = 1;
    repeat (2) begin @(posedge clk); #1; n++; end
    drive(8, 1'b1, 32'hFF, 32'h11, 1'b0);
    @(posedge clk); #1; n++;
    drive(8, 1'b0, 32'hFF, 32'h11, 1'b0);
    while (busy8 && n < 64) begin @(posedge clk); #1; n++; end
    chk("midrun_latency", 64'(n), 64'd9);
    chk("midrun_done", {63'd0, done8}, 64'd1);
    chk("midrun_result", {54'd0, cout8, ovf8, sum8}, {54'd0, 2'b00, 8'hFE});
    dcount = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) dcount++; end
    chk("midrun_no_extra_done", 64'(dcount), 64'd0);

    // Back-to-back with start held high.
    drive(8, 1'b1, 32'd1, 32'd1, 1'b0);
    @(posedge clk); #1;
    t = 1;
    while (!done8 && t < 40) begin @(posedge clk); #1; t++; end
    chk("b2b_first_done_cycle", 64'(t), 64'd9);
    chk("b2b_first_sum", {56'd0, sum8}, 64'd2);
    drive(8, 1'b1, 32'd2, 32'd3, 1'b0);
    t = 0;
    do begin
      @(posedge clk); #1; t++;
      if (t == 4) chk("b2b_sum_held_during_run", {56'd0, sum8}, 64'd2);
    end while (!done8 && t < 40);
    drive(8, 1'b0, 32'd2, 32'd3, 1'b0);
    chk("b2b_done_spacing", 64'(t), 64'd9);
    chk("b2b_second_sum", {56'd0, sum8}, 64'd5);
    @(posedge clk); #1;
    chk("b2b_not_restarted", {62'd0, busy8, done8}, 64'd0);

    // Reset mid-run after a result with cout=1, ovf=1.
    op8_check("pre_reset_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    drive(8, 1'b1, 32'd200, 32'd100, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'd200, 32'd100, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_busy_before", {63'd0, busy8}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("reset_midrun_outputs", {45'd0, sum8, cout8, ovf8, busy8, done8}, 64'd0);
    dcount = 0;
    repeat (12) begin @(posedge clk); #1; if (done8 || busy8) dcount++; end
    chk("reset_no_later_done", 64'(dcount), 64'd0);

    // Reset and start together: reset wins.
    rst_n = 1'b0;
    drive(8, 1'b1, 32'd9, 32'd9, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(8, 1'b0, 32'd9, 32'd9, 1'b0);
    chk("reset_beats_start", {62'd0, busy8, done8}, 64'd0);
    @(posedge clk); #1;
    chk("reset_beats_start_idle", {62'd0, busy8, done8}, 64'd0);

    op8_check("after_reset_add", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0);

    // WIDTH=2 exhaustive.
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          run_op(2, 32'(a), 32'(b), s[0], n);
          if (n != 2 || !done2)
            chk("w2_handshake", {32'(n), 31'd0, done2}, {32'd2, 32'd1});
          chk($sformatf("w2_a%0d_b%0d_s%0d", a, b, s), {30'd0, res_of(2)},
              {30'd0, model(2, 32'(a), 32'(b), s[0])});
        end

    // WIDTH=32 random.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_op(32, ra, rb, rs, n);
      if (n != 32 || !done32)
        chk("w32_handshake", {32'(n), 31'd0, done32}, {32'd32, 32'd1});
      chk($sformatf("w32_op%0d", i), {30'd0, res_of(32)}, {30'd0, model(32, ra, rb, rs)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
